ssd_port_arbiter: RTL
=====================

# ssd_port_arbiter

Round-robin arbiter that shares the single SSD controller command port between `NUM_REQ` block-queue requesters. It sits between the per-host `io_chip` SSD-side outputs and the SSD controller. It accepts one command at a time and holds the grant until the SSD signals completion (`ssd_data_ready`) or a watchdog expires. It then returns a per-requester done or timeout pulse.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8).
- `TIMEOUT_CYCLES`, 1024, maximum cycles spent in WAIT_DONE (minimum 2).
- `GW`, `$clog2(NUM_REQ)`, grant index width (derived, not overridden).

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a command.
- `req_ready` out NUM_REQ: one-hot accept; the transfer occurs on `req_valid[i] & req_ready[i]`.
- `req_opcode` in 8·NUM_REQ: packed opcodes; requester i occupies bits [8i+7:8i].
- `req_lba` in 64·NUM_REQ: packed LBAs.
- `req_length` in 32·NUM_REQ: packed byte lengths.
- `req_data` in 64·NUM_REQ: packed data words.
- `req_done` out NUM_REQ: one-cycle completion pulse to the granted requester.
- `req_timeout` out NUM_REQ: one-cycle watchdog pulse to the granted requester.
- `ssd_cmd_valid` out 1: command presented to the SSD.
- `ssd_cmd_ready` in 1: SSD accepts the command.
- `ssd_opcode` out 8, `ssd_lba` out 64, `ssd_length` out 32, `ssd_data` out 64: latched command fields.
- `ssd_data_ready` in 1: SSD completion strobe.
- `busy` out 1: high when the state is not IDLE.
- `grant_id` out GW: index of the current or most recent grant.
- `timeout_count` out 16: saturating count of watchdog expiries.

## Operation
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - Winner = first i with `req_valid[i]`, searching upward from `last_grant+1` modulo NUM_REQ.
  - `req_ready` is combinationally one-hot on the winner; it is all-zero when no request is present or the state is not IDLE.
  - On accept: latch opcode, lba, length and data of the winner into holding registers; `grant_id <= winner`; go to ISSUE.
- ISSUE:
  - `ssd_cmd_valid = 1`; `ssd_*` outputs are driven from the holding registers.
  - On `ssd_cmd_ready`: go to WAIT_DONE and clear the timer.
  - Otherwise stay in ISSUE; the fields stay stable and there is no timeout in ISSUE.
- WAIT_DONE:
  - The timer increments each cycle.
  - If `ssd_data_ready` is high: `req_done[grant_id] <= 1` for one cycle; `last_grant <= grant_id`; go to IDLE.
  - Else if timer == TIMEOUT_CYCLES-1: `req_timeout[grant_id] <= 1` for one cycle; `timeout_count` increments, saturating at 0xFFFF; `last_grant <= grant_id`; go to IDLE.
- Holding registers hold their value after completion. `ssd_*` field outputs may show stale values whenever `ssd_cmd_valid` = 0.
- `ssd_data_ready` is ignored in IDLE and ISSUE.
- A requester that drops `req_valid` before it is granted is simply skipped.
- Reset values:
  - State IDLE; `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - `grant_id` = 0; timer = 0; `timeout_count` = 0; all holding registers = 0.
  - `req_done`, `req_timeout` and `ssd_cmd_valid` = 0; `busy` = 0.
- Reset asserted mid-command (ISSUE or WAIT_DONE) aborts immediately with no done or timeout pulse.

## Timing
- Accept in cycle T (IDLE) → `ssd_cmd_valid` high in T+1.
- With `ssd_cmd_ready` high in T+1, the state is WAIT_DONE in T+2.
- `ssd_data_ready` sampled high in cycle D → `req_done` high in D+1 only; the state is IDLE in D+1, so a new accept is possible in D+1.
- Minimum spacing between accepts: 3 cycles plus SSD latency.
- WAIT_DONE lasts at most TIMEOUT_CYCLES cycles. The timeout pulse appears in the cycle after the expiry cycle.
- `ssd_data_ready` in the same cycle as timer expiry: done wins; there is no timeout pulse and no counter increment.
- `req_done` and `req_timeout` are registered, at most one bit of one of them is high in any cycle, and they are never high together.
- `busy` is registered from state; it is high from T+1 through the cycle of completion or expiry.

## Test plan
- Single request, instant SSD: `req_valid`=0001, opcode=1, lba=4096, len=8192, `ssd_cmd_ready`=1, `ssd_data_ready` 2 cycles after issue.
  - Required: `ssd_lba`=4096 and `ssd_length`=8192 at T+1; `req_done`=0001 exactly once.
  - Required: `grant_id`=0 and `timeout_count`=0.
- Fairness: `req_valid`=1111 held continuously for 8 commands → grant order 0,1,2,3,0,1,2,3; each `req_done` bit pulses exactly twice.
- Backpressure: `ssd_cmd_ready` low for 5 cycles after issue → `ssd_cmd_valid` held 6 cycles with constant fields; no timeout.
- Watchdog: TIMEOUT_CYCLES=16 and `ssd_data_ready` never asserted → `req_timeout[grant]` pulses 16 cycles after entering WAIT_DONE; `timeout_count`=1; IDLE next; the next requester is granted.
- Collision: `ssd_data_ready` arrives exactly on cycle 16 with TIMEOUT_CYCLES=16 → only `req_done` pulses; `timeout_count` is unchanged.
- Reset mid-WAIT_DONE: `rst` pulsed → all outputs return to reset values asynchronously; no pulses; the next grant goes to requester 0.

Source files
------------

// File: rtl/ssd_port_arbiter.sv
// ssd_port_arbiter: round-robin arbiter sharing the SSD controller command port
// between NUM_REQ block-queue requesters. One command is in flight at a time.
// The grant is held until the SSD signals completion or the watchdog expires.
module ssd_port_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned GW            = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [8*NUM_REQ-1:0]    req_opcode,
    input  logic [64*NUM_REQ-1:0]   req_lba,
    input  logic [32*NUM_REQ-1:0]   req_length,
    input  logic [64*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [NUM_REQ-1:0]      req_timeout,

    output logic                    ssd_cmd_valid,
    input  logic                    ssd_cmd_ready,
    output logic [7:0]              ssd_opcode,
    output logic [63:0]             ssd_lba,
    output logic [31:0]             ssd_length,
    output logic [63:0]             ssd_data,
    input  logic                    ssd_data_ready,

    output logic                    busy,
    output logic [GW-1:0]           grant_id,
    output logic [15:0]             timeout_count
);

    // Timer only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

    state_e               state_q, state_d;
    logic [GW-1:0]        last_grant_q;
    logic [GW-1:0]        grant_id_q;
    logic [TW-1:0]        timer_q;
    logic [15:0]          timeout_count_q;
    logic [7:0]           opcode_q;
    logic [63:0]          lba_q;
    logic [31:0]          length_q;
    logic [63:0]          data_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [NUM_REQ-1:0]   timeout_q;

    logic                 win_found;
    logic [GW-1:0]        win_idx;
    logic                 expire;

    assign expire = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // Round-robin search: first valid requester at or after last_grant+1.
    // Scanning downward lets the closest candidate overwrite farther ones.
    always_comb begin
        int            idx;
        logic [GW-1:0] sel;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        sel       = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            idx = (int'(last_grant_q) + k) % int'(NUM_REQ);
            sel = GW'(idx);
            if (req_valid[sel]) begin
                win_found = 1'b1;
                win_idx   = sel;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; completion takes priority over watchdog expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (win_found) state_d = StIssue;
            StIssue:    if (ssd_cmd_ready) state_d = StWaitDone;
            StWaitDone: if (ssd_data_ready || expire) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        req_ready     = '0;
        ssd_cmd_valid = 1'b0;
        busy          = (state_q != StIdle);
        if (state_q == StIdle && win_found) begin
            req_ready = NUM_REQ'(1) << win_idx;
        end
        if (state_q == StIssue) begin
            ssd_cmd_valid = 1'b1;
        end
    end

    // Command capture, watchdog timer, completion pulses and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q    <= GW'(NUM_REQ - 1);
            grant_id_q      <= '0;
            timer_q         <= '0;
            timeout_count_q <= '0;
            opcode_q        <= '0;
            lba_q           <= '0;
            length_q        <= '0;
            data_q          <= '0;
            done_q          <= '0;
            timeout_q       <= '0;
        end else begin
            done_q    <= '0;
            timeout_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        opcode_q   <= req_opcode[8*int'(win_idx) +: 8];
                        lba_q      <= req_lba[64*int'(win_idx) +: 64];
                        length_q   <= req_length[32*int'(win_idx) +: 32];
                        data_q     <= req_data[64*int'(win_idx) +: 64];
                        grant_id_q <= win_idx;
                    end
                end
                StIssue: begin
                    if (ssd_cmd_ready) begin
                        timer_q <= '0;
                    end
                end
                StWaitDone: begin
                    timer_q <= timer_q + 1'b1;
                    if (ssd_data_ready) begin
                        done_q       <= NUM_REQ'(1) << grant_id_q;
                        last_grant_q <= grant_id_q;
                    end else if (expire) begin
                        timeout_q    <= NUM_REQ'(1) << grant_id_q;
                        last_grant_q <= grant_id_q;
                        if (timeout_count_q != 16'hFFFF) begin
                            timeout_count_q <= timeout_count_q + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ssd_opcode    = opcode_q;
    assign ssd_lba       = lba_q;
    assign ssd_length    = length_q;
    assign ssd_data      = data_q;
    assign grant_id      = grant_id_q;
    assign timeout_count = timeout_count_q;
    assign req_done      = done_q;
    assign req_timeout   = timeout_q;

endmodule
